// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking-entrance sensor logic.
package parking_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

  typedef enum logic [2:0] {
    IDLE,
    ENT_1,
    ENT_2,
    ENT_3,
    EXT_1,
    EXT_2,
    EXT_3,
    FAULT
  } sensor_state_t;

  typedef struct packed {
    logic entering;
    logic exiting;
    logic fault;
  } seq_pulse_t;

endpackage

// File: rtl/sensor_sequence_fsm_if.sv
// Beam-sensor inputs and sequence-event outputs of the entrance detector.
interface sensor_sequence_fsm_if;

  logic sensor_a;
  logic sensor_b;
  logic entering;
  logic exiting;
  logic fault;
  logic busy;

  modport master (
    output sensor_a, sensor_b,
    input  entering, exiting, fault, busy
  );

  modport slave (
    input  sensor_a, sensor_b,
    output entering, exiting, fault, busy
  );

endinterface

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one beam.
module sensor_debouncer
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking updates would let sync[1] see this cycle's sync[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_sequence_fsm.sv
// Decodes the debounced two-beam pattern into entry, exit and fault pulses.
module sensor_sequence_fsm
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  sensor_sequence_fsm_if.slave  bus
);

  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(TIMEOUT_CYCLES - 1);

  logic          a_db;
  logic          b_db;
  logic [1:0]    p;
  sensor_state_t state;
  sensor_state_t state_next;
  logic [DW-1:0] dwell;
  logic          timed_out;
  seq_pulse_t    pulse;
  seq_pulse_t    pulse_next;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sensor_a),
    .level (a_db)
  );

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sensor_b),
    .level (b_db)
  );

  assign p = {a_db, b_db};

  // dwell holds cycles already spent in the state, so DWELL_LAST marks the
  // TIMEOUT_CYCLES-th cycle; only the sequence states can time out.
  assign timed_out = (state != IDLE) && (state != FAULT) && (dwell == DWELL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dwell <= '0;
      pulse <= '0;
    end else begin
      state <= state_next;
      pulse <= pulse_next;
      if (state_next != state) begin
        dwell <= '0;
      end else if (dwell != DWELL_MAX) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // NOTE: state_next gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        case (p)
          2'b10:   state_next = ENT_1;
          2'b01:   state_next = EXT_1;
          2'b11:   state_next = FAULT;
          default: state_next = IDLE;
        endcase
      end
      ENT_1: begin
        case (p)
          2'b11:   state_next = ENT_2;
          2'b00:   state_next = IDLE;
          2'b01:   state_next = FAULT;
          default: state_next = ENT_1;
        endcase
      end
      ENT_2: begin
        case (p)
          2'b01:   state_next = ENT_3;
          2'b10:   state_next = ENT_1;
          2'b00:   state_next = FAULT;
          default: state_next = ENT_2;
        endcase
      end
      ENT_3: begin
        case (p)
          2'b00:   state_next = IDLE;
          2'b11:   state_next = ENT_2;
          2'b10:   state_next = FAULT;
          default: state_next = ENT_3;
        endcase
      end
      EXT_1: begin
        case (p)
          2'b11:   state_next = EXT_2;
          2'b00:   state_next = IDLE;
          2'b10:   state_next = FAULT;
          default: state_next = EXT_1;
        endcase
      end
      EXT_2: begin
        case (p)
          2'b10:   state_next = EXT_3;
          2'b01:   state_next = EXT_1;
          2'b00:   state_next = FAULT;
          default: state_next = EXT_2;
        endcase
      end
      EXT_3: begin
        case (p)
          2'b00:   state_next = IDLE;
          2'b11:   state_next = EXT_2;
          2'b01:   state_next = FAULT;
          default: state_next = EXT_3;
        endcase
      end
      FAULT: begin
        if (p == 2'b00) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A real pattern change wins over a timeout landing on the same cycle.
    if (timed_out && (state_next == state)) state_next = FAULT;
  end

  always_comb begin
    pulse_next          = '0;
    pulse_next.entering = (state == ENT_3) && (p == 2'b00);
    pulse_next.exiting  = (state == EXT_3) && (p == 2'b00);
    pulse_next.fault    = (state_next == FAULT) && (state != FAULT);
  end

  assign bus.entering = pulse.entering;
  assign bus.exiting  = pulse.exiting;
  assign bus.fault    = pulse.fault;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_sensor_sequence_fsm.sv
// Self-checking bench: pattern table with a pulse scoreboard plus corner-case sequences.
module tb_sensor_sequence_fsm;

  localparam int DEB  = 4;
  localparam int TMO  = 50;
  localparam int HOLD = 10;
  localparam int LAT  = 2 + DEB + 1;   // raw edge -> registered pulse

  localparam logic [2:0] EV_NONE  = 3'b000;
  localparam logic [2:0] EV_ENTER = 3'b100;
  localparam logic [2:0] EV_EXIT  = 3'b010;
  localparam logic [2:0] EV_FAULT = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         due;
  } exp_t;

  typedef struct {
    logic [11:0] pats;     // six 2-bit {a,b} steps, first step in the MSBs
    int          ev_step;  // step whose drive produces the event, -1 for none
    logic [2:0]  kind;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];
  vec_t vecs[12];

  logic [2:0] mon_k;
  exp_t       mon_e;

  sensor_sequence_fsm_if bus();

  sensor_sequence_fsm #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic [1:0] pat);
    bus.sensor_a = pat[1];
    bus.sensor_b = pat[0];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every pulse must match the oldest outstanding expectation in kind and cycle.
  always @(negedge clk) begin
    if (reset) begin
      mon_k = {bus.entering, bus.exiting, bus.fault};
      if (mon_k != 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'(mon_k), 32'(EV_NONE));
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind", 32'(mon_k), 32'(mon_e.kind));
          check("pulse_cycle", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int   c;
    logic seen;

    vecs[0]  = '{12'b10_11_01_00_00_00,  3, EV_ENTER, "enter"};
    vecs[1]  = '{12'b01_11_10_00_00_00,  3, EV_EXIT,  "exit"};
    vecs[2]  = '{12'b10_11_10_00_00_00, -1, EV_NONE,  "ent_backout"};
    vecs[3]  = '{12'b11_00_00_00_00_00,  0, EV_FAULT, "idle_both"};
    vecs[4]  = '{12'b10_01_00_00_00_00,  1, EV_FAULT, "ent1_swap"};
    vecs[5]  = '{12'b10_11_00_00_00_00,  2, EV_FAULT, "ent2_clear"};
    vecs[6]  = '{12'b10_11_01_11_01_00,  5, EV_ENTER, "ent3_retreat"};
    vecs[7]  = '{12'b10_11_01_10_00_00,  3, EV_FAULT, "ent3_bad"};
    vecs[8]  = '{12'b01_11_01_00_00_00, -1, EV_NONE,  "ext_backout"};
    vecs[9]  = '{12'b01_10_00_00_00_00,  1, EV_FAULT, "ext1_swap"};
    vecs[10] = '{12'b01_11_10_01_00_00,  3, EV_FAULT, "ext3_bad"};
    vecs[11] = '{12'b01_11_10_11_10_00,  5, EV_EXIT,  "ext3_retreat"};

    drive(2'b00);
    wait_cycles(3);
    check("reset_entering", 32'(bus.entering), 0);
    check("reset_exiting",  32'(bus.exiting),  0);
    check("reset_fault",    32'(bus.fault),    0);
    check("reset_busy",     32'(bus.busy),     0);
    reset = 1'b1;
    wait_cycles(3);

    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < 6; s++) begin
        drive(vecs[i].pats[11 - 2*s -: 2]);
        if (s == vecs[i].ev_step) sb.push_back('{vecs[i].kind, cyc + LAT});
        wait_cycles(HOLD);
      end
      check({vecs[i].name, "_pending"}, sb.size(), 0);
      check({vecs[i].name, "_busy_end"}, 32'(bus.busy), 0);
      sb.delete();
    end

    // 3-cycle glitch on a must be filtered; 4 cycles is just enough to register.
    seen = 1'b0;
    drive(2'b10);
    wait_cycles(3);
    drive(2'b00);
    for (int k = 0; k < 15; k++) begin
      wait_cycles(1);
      seen |= bus.busy;
    end
    check("glitch3_busy", 32'(seen), 0);

    seen = 1'b0;
    drive(2'b10);
    wait_cycles(4);
    drive(2'b00);
    for (int k = 0; k < 15; k++) begin
      wait_cycles(1);
      seen |= bus.busy;
    end
    check("glitch4_busy", 32'(seen), 1);
    check("glitch4_idle", 32'(bus.busy), 0);

    // Dwell timeout in ENT_1, then FAULT holds until the beams clear.
    c = cyc;
    drive(2'b10);
    sb.push_back('{EV_FAULT, c + LAT + TMO});
    wait_cycles(60);
    check("timeout_pending", sb.size(), 0);
    check("timeout_in_fault", 32'(bus.busy), 1);
    drive(2'b00);
    wait_cycles(LAT - 1);
    check("timeout_fault_hold", 32'(bus.busy), 1);
    wait_cycles(2);
    check("timeout_released", 32'(bus.busy), 0);
    sb.delete();

    // Reset in ENT_2 discards the sequence.
    drive(2'b10);
    wait_cycles(HOLD);
    drive(2'b11);
    wait_cycles(HOLD);
    check("ent2_busy", 32'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    check("async_entering", 32'(bus.entering), 0);
    check("async_exiting",  32'(bus.exiting),  0);
    check("async_fault",    32'(bus.fault),    0);
    check("async_busy",     32'(bus.busy),     0);
    drive(2'b00);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(20);
    check("post_reset_idle", 32'(bus.busy), 0);

    // A beam still blocked after reset release starts a fresh sequence.
    drive(2'b10);
    wait_cycles(HOLD);
    check("ent1_busy", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("ent1_reset_busy", 32'(bus.busy), 0);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(HOLD);
    check("redetect_busy", 32'(bus.busy), 1);
    drive(2'b00);
    wait_cycles(HOLD + 2);
    check("redetect_backout", 32'(bus.busy), 0);
    check("final_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
